// File: rtl/frame101_pkg.sv
// Shared definitions for the "101" framed serial path.
package frame101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_e;

    localparam logic [2:0]  PREAMBLE = 3'b101;
    localparam int unsigned PRE_LEN  = 3;

    // Largest of three values, used to size the shared phase counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_tx101_piso_shift.sv
// Parallel-in / serial-out shift register, MSB first.
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q;

    // Load wins over shift; zeros fill from the LSB side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/frame_tx101.sv
// Bit-serial frame transmitter: preamble 101, W data bits MSB-first, GAP_LEN zeros.
module frame_tx101
    import frame101_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned GAP_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data,
    input  logic         valid,
    output logic         ready,
    output logic         out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(max3(PRE_LEN, W, GAP_LEN) + 1);

    if (W == 0 || W > 32 || GAP_LEN == 0 || GAP_LEN > 16) begin : g_param_check
        $error("frame_tx101: W must be 1..32 and GAP_LEN must be 1..16");
    end

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          out_q;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;

    logic          load_c;
    logic          shift_c;
    logic          msb_c;

    // Accept happens only in IDLE; shift once per emitted data bit.
    assign load_c  = (state_q == IDLE) && valid && ready_q;
    assign shift_c = ((state_q == PRE)  && (cnt_q == CW'(PRE_LEN - 1))) ||
                     ((state_q == DATA) && (cnt_q != CW'(W - 1)));

    piso_shift #(
        .W (W)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load_c),
        .shift (shift_c),
        .din   (data),
        .msb   (msb_c)
    );

    // Frame sequencer: state, shared counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_c) begin
                        state_q <= PRE;
                        cnt_q   <= '0;
                        out_q   <= PREAMBLE[2];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        out_q <= 1'b0;
                    end
                end
                PRE: begin
                    if (cnt_q == CW'(PRE_LEN - 1)) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        out_q   <= msb_c;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        out_q <= (cnt_q == '0) ? PREAMBLE[1] : PREAMBLE[0];
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        out_q <= msb_c;
                    end
                end
                GAP: begin
                    out_q <= 1'b0;
                    if (cnt_q == CW'(GAP_LEN - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_frame_tx101.sv
// Directed self-checking bench for frame_tx101 (W=8, GAP_LEN=2).
module tb_frame_tx101;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    frame_tx101 #(
        .W       (8),
        .GAP_LEN (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Mealy 101 detector (overlapping) fed from the serial line.
    logic [1:0] ms;
    logic       det;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms <= 2'd0;
        end else begin
            case (ms)
                2'd0:    ms <= out ? 2'd1 : 2'd0;
                2'd1:    ms <= out ? 2'd1 : 2'd2;
                default: ms <= out ? 2'd1 : 2'd0;
            endcase
        end
    end
    assign det = (ms == 2'd2) && out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line value after edge Ek of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k < 3)       return (k != 1);
        else if (k < 11) return d[10-k];
        else             return 1'b0;
    endfunction

    // Entered just after the accept edge E0; returns just after E13.
    task automatic check_frame(input logic [7:0] d, input string name);
        for (int k = 0; k <= 12; k++) begin
            check($sformatf("%s out E%0d", name, k), 32'(out), 32'(exp_bit(d, k)));
            check($sformatf("%s busy E%0d", name, k), 32'(busy), 32'd1);
            check($sformatf("%s ready E%0d", name, k), 32'(ready), 32'd0);
            check($sformatf("%s done E%0d", name, k), 32'(done), 32'd0);
            tick();
        end
        check($sformatf("%s done E13", name), 32'(done), 32'd1);
        check($sformatf("%s ready E13", name), 32'(ready), 32'd1);
        check($sformatf("%s busy E13", name), 32'(busy), 32'd0);
        check($sformatf("%s out E13", name), 32'(out), 32'd0);
    endtask

    int det_cnt;
    int det_idx;

    initial begin
        rst   = 1'b1;
        data  = 8'h00;
        valid = 1'b0;

        // Reset state, then idle
        #2;
        check("rst out", 32'(out), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle%0d out", i), 32'(out), 32'd0);
            check($sformatf("idle%0d ready", i), 32'(ready), 32'd1);
            check($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
            check($sformatf("idle%0d done", i), 32'(done), 32'd0);
        end

        // Single frame A5
        data  = 8'hA5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        data  = 8'h00;
        check_frame(8'hA5, "a5");
        tick();
        check("a5 done E14", 32'(done), 32'd0);
        check("a5 ready E14", 32'(ready), 32'd1);

        // valid held high: FF, then 00 offered while busy and at the done cycle
        data  = 8'hFF;
        valid = 1'b1;
        tick();
        data  = 8'h00;
        check_frame(8'hFF, "ff");
        tick();
        check_frame(8'h00, "00");
        valid = 1'b0;
        tick();
        check("00 done after", 32'(done), 32'd0);

        // Data changes after accept have no effect
        data  = 8'hC3;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        data  = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("c3 out E%0d", k), 32'(out), 32'(exp_bit(8'hC3, k)));
            tick();
        end
        tick();
        tick();
        check("c3 done", 32'(done), 32'd1);
        tick();

        // Reset mid-frame at E5
        data  = 8'h5A;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (5) tick();
        check("5a out E5", 32'(out), 32'(exp_bit(8'h5A, 5)));
        check("5a busy E5", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst out", 32'(out), 32'd0);
        check("midrst ready", 32'(ready), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("postrst out", 32'(out), 32'd0);
        check("postrst ready", 32'(ready), 32'd1);
        data  = 8'h3C;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check_frame(8'h3C, "3c");
        tick();
        tick();

        // Loopback into a Mealy 101 detector
        det_cnt = 0;
        det_idx = -1;
        check("lb pre det", 32'(det), 32'd0);
        data  = 8'h00;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (det) begin
                det_cnt++;
                det_idx = k;
            end
            tick();
        end
        check("lb det count", 32'(det_cnt), 32'd1);
        check("lb det cycle", 32'(det_idx), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
